// File: rtl/mp64_extmem_ctrl.sv
// External-memory PHY initiator: takes 1-16 beat 64-bit client transactions,
// stages write beats in a 16-entry buffer, sequences them to the PHY and returns read beats.
module mp64_extmem_ctrl #(
  parameter int PHY_WR_LAT = 2,
  parameter int TIMEOUT    = 1024,
  parameter int ADDR_W     = 32
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              cli_req,
  input  logic              cli_wen,
  input  logic [ADDR_W-1:0] cli_addr,
  input  logic [3:0]        cli_len,
  input  logic              cli_wpush,
  input  logic [63:0]       cli_wdata,
  output logic [4:0]        cli_wcount,
  output logic              cli_ack,
  output logic              cli_rvalid,
  output logic [63:0]       cli_rdata,
  output logic [3:0]        cli_rbeat,
  output logic              cli_done,
  output logic              cli_err,
  output logic              busy,
  output logic              phy_req,
  output logic [ADDR_W-1:0] phy_addr,
  output logic              phy_wen,
  output logic [63:0]       phy_wdata,
  output logic [3:0]        phy_burst_len,
  input  logic [63:0]       phy_rdata,
  input  logic              phy_rvalid,
  input  logic              phy_ready
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int LW = $clog2(PHY_WR_LAT + 1);

  typedef enum logic [2:0] {IDLE, ISSUE, RD_WAIT, WR_LAT, WR_DATA, WR_DRAIN} state_t;
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [3:0]        len;
    logic              wen;
  } phy_req_t;

  state_t            state;
  phy_req_t          phy_q;
  logic [15:0][63:0] wbuf;
  logic [3:0]        beat;
  logic [LW-1:0]     lat_cnt;
  logic [TW-1:0]     tmr;
  logic              wr_ok, push_ok;
  logic              unused_addr_lsb;

  assign unused_addr_lsb = ^cli_addr[2:0];
  assign wr_ok   = (cli_wcount == ({1'b0, cli_len} + 5'd1));
  // an accepted write freezes the buffer, so a push in the same cycle is dropped
  assign push_ok = (state == IDLE) && cli_wpush && !cli_wcount[4] &&
                   !(cli_req && cli_wen && wr_ok);

  assign busy          = (state != IDLE);
  assign phy_addr      = phy_q.addr;
  assign phy_wen       = phy_q.wen;
  assign phy_burst_len = phy_q.len;
  assign phy_wdata     = wbuf[beat];

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state      <= IDLE;
      phy_q      <= '0;
      phy_req    <= 1'b0;
      wbuf       <= '0;
      beat       <= '0;
      lat_cnt    <= '0;
      tmr        <= '0;
      cli_wcount <= '0;
      cli_ack    <= 1'b0;
      cli_rvalid <= 1'b0;
      cli_rdata  <= '0;
      cli_rbeat  <= '0;
      cli_done   <= 1'b0;
      cli_err    <= 1'b0;
    end else begin
      cli_ack    <= 1'b0;
      cli_done   <= 1'b0;
      cli_err    <= 1'b0;
      cli_rvalid <= 1'b0;
      if (push_ok) begin
        wbuf[cli_wcount[3:0]] <= cli_wdata;
        cli_wcount            <= cli_wcount + 5'd1;
      end
      case (state)
        IDLE: if (cli_req) begin
          cli_ack <= 1'b1;
          if (cli_wen && !wr_ok) cli_err <= 1'b1;
          else begin
            phy_q   <= '{addr: {cli_addr[ADDR_W-1:3], 3'b000}, len: cli_len, wen: cli_wen};
            phy_req <= 1'b1;
            state   <= ISSUE;
          end
        end
        ISSUE: if (phy_ready) begin
          phy_req <= 1'b0;
          beat    <= '0;
          tmr     <= '0;
          if (!phy_q.wen) state <= RD_WAIT;
          else if (PHY_WR_LAT <= 1) state <= WR_DATA;
          else begin
            state   <= WR_LAT;
            lat_cnt <= LW'(PHY_WR_LAT - 1);
          end
        end
        RD_WAIT: begin
          if (phy_rvalid) begin
            cli_rvalid <= 1'b1;
            cli_rdata  <= phy_rdata;
            cli_rbeat  <= beat;
            beat       <= beat + 4'd1;
            tmr        <= '0;
            if (beat == phy_q.len) begin
              cli_done <= 1'b1;
              state    <= IDLE;
            end
          end else if (tmr == TW'(TIMEOUT - 1)) begin
            cli_err <= 1'b1;
            state   <= IDLE;
          end else tmr <= tmr + TW'(1);
        end
        // the cycle ending each WR_DATA edge is the one the PHY samples phy_wdata
        WR_LAT: if (lat_cnt <= LW'(1)) state <= WR_DATA;
                else lat_cnt <= lat_cnt - LW'(1);
        WR_DATA: if (beat == phy_q.len) state <= WR_DRAIN;
                 else beat <= beat + 4'd1;
        WR_DRAIN: if (phy_ready) begin
          cli_done   <= 1'b1;
          cli_wcount <= '0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mp64_extmem_ctrl.sv
// Directed bench for mp64_extmem_ctrl with a behavioural PHY and word memory.
module tb_mp64_extmem_ctrl;
  localparam int PWL = 2, TMO = 64, AW = 32, RD_LAT = 2;

  logic sys_clk = 1'b0, sys_rst = 1'b1;
  logic cli_req = 1'b0, cli_wen = 1'b0, cli_wpush = 1'b0;
  logic [AW-1:0] cli_addr = '0;
  logic [3:0] cli_len = '0;
  logic [63:0] cli_wdata = '0;
  logic [4:0] cli_wcount;
  logic cli_ack, cli_rvalid, cli_done, cli_err, busy;
  logic [63:0] cli_rdata;
  logic [3:0] cli_rbeat;
  logic phy_req, phy_wen;
  logic [AW-1:0] phy_addr;
  logic [63:0] phy_wdata;
  logic [3:0] phy_burst_len;
  logic [63:0] phy_rdata = '0;
  logic phy_rvalid = 1'b0, phy_ready = 1'b1;

  mp64_extmem_ctrl #(.PHY_WR_LAT(PWL), .TIMEOUT(TMO), .ADDR_W(AW)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .cli_req(cli_req), .cli_wen(cli_wen), .cli_addr(cli_addr), .cli_len(cli_len),
    .cli_wpush(cli_wpush), .cli_wdata(cli_wdata), .cli_wcount(cli_wcount),
    .cli_ack(cli_ack), .cli_rvalid(cli_rvalid), .cli_rdata(cli_rdata), .cli_rbeat(cli_rbeat),
    .cli_done(cli_done), .cli_err(cli_err), .busy(busy),
    .phy_req(phy_req), .phy_addr(phy_addr), .phy_wen(phy_wen), .phy_wdata(phy_wdata),
    .phy_burst_len(phy_burst_len), .phy_rdata(phy_rdata), .phy_rvalid(phy_rvalid),
    .phy_ready(phy_ready)
  );

  always #5 sys_clk = ~sys_clk;

  int nvec = 0, nmis = 0;
  logic [63:0] mem [0:4095];
  bit ph_act = 0, ph_wq = 0, rd_mute = 0;
  int ph_t = 0, ph_word = 0, ph_len = 0;
  int cyc = 0, acc_cyc = 0, err_cyc = 0;
  int preq_n = 0, done_n = 0, err_n = 0, rd_n = 0;
  logic [63:0] rd_data [0:31];
  logic [3:0]  rd_beat [0:31];
  logic        rd_last [0:31];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // PHY model: runs just after the falling edge, so it sees this cycle's settled inputs
  always @(negedge sys_clk) begin
    #1;
    phy_rvalid = 1'b0;
    if (sys_rst) ph_act = 0;
    else begin
      if (ph_act) begin
        ph_t++;
        if (ph_wq) begin
          if (ph_t >= PWL && ph_t <= PWL + ph_len) mem[ph_word + ph_t - PWL] = phy_wdata;
          if (ph_t >= PWL + ph_len) ph_act = 0;
        end else begin
          if (ph_t >= RD_LAT) begin
            phy_rvalid = 1'b1;
            phy_rdata  = mem[ph_word + ph_t - RD_LAT];
          end
          if (ph_t >= RD_LAT + ph_len) ph_act = 0;
        end
      end
      if (phy_req && phy_ready && !ph_act) begin
        ph_act  = !(rd_mute && !phy_wen);
        ph_t    = 0;
        ph_len  = int'(phy_burst_len);
        ph_wq   = phy_wen;
        ph_word = int'(phy_addr >> 3);
        acc_cyc = cyc + 1;
      end
    end
  end

  always @(posedge sys_clk) begin
    #1;
    cyc++;
    if (phy_req) preq_n++;
    if (cli_done) done_n++;
    if (cli_err) begin err_n++; err_cyc = cyc; end
    if (cli_rvalid && rd_n < 32) begin
      rd_data[rd_n] = cli_rdata;
      rd_beat[rd_n] = cli_rbeat;
      rd_last[rd_n] = cli_done;
      rd_n++;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic push(input logic [63:0] d);
    cli_wpush = 1'b1; cli_wdata = d;
    tick();
    cli_wpush = 1'b0;
  endtask

  task automatic req(input logic w, input logic [AW-1:0] a, input logic [3:0] l);
    cli_req = 1'b1; cli_wen = w; cli_addr = a; cli_len = l;
    tick();
    cli_req = 1'b0;
  endtask

  task automatic wait_end(input string tag, input int budget);
    int d0, k;
    d0 = done_n + err_n;
    k = 0;
    while (done_n + err_n == d0 && k < budget) begin tick(); k++; end
    chk(tag, 64'(k < budget), 1);
  endtask

  initial begin
    int d, e, p, k;
    for (int i = 0; i < 4096; i++) mem[i] = '0;
    tick(2);
    chk("rst_preq", phy_req, 0);
    chk("rst_wcnt", cli_wcount, 0);
    chk("rst_busy", busy, 0);
    sys_rst = 1'b0;
    tick();

    // single read with ISSUE held by phy_ready low
    mem[32'h100 >> 3] = 64'hDEADBEEF_CAFEF00D;
    phy_ready = 1'b0; rd_n = 0; e = err_n;
    req(1'b0, 32'h100, 4'd0);
    chk("rd1_ack", cli_ack, 1);
    tick(3);
    chk("rd1_hold", phy_req, 1);
    chk("rd1_addr", phy_addr, 32'h100);
    chk("rd1_blen", phy_burst_len, 0);
    chk("rd1_busy", busy, 1);
    phy_ready = 1'b1;
    wait_end("rd1_end", 50);
    chk("rd1_n", rd_n, 1);
    chk("rd1_data", rd_data[0], 64'hDEADBEEF_CAFEF00D);
    chk("rd1_beat", rd_beat[0], 0);
    chk("rd1_last", rd_last[0], 1);
    chk("rd1_noerr", err_n, e);

    // burst write of four beats
    push(64'h11); push(64'h22); push(64'h33); push(64'h44);
    chk("wr4_wcnt", cli_wcount, 4);
    d = done_n; p = preq_n;
    req(1'b1, 32'h2000, 4'd3);
    chk("wr4_ack", cli_ack, 1);
    chk("wr4_wen", phy_wen, 1);
    wait_end("wr4_end", 50);
    for (int i = 0; i < 4; i++) chk($sformatf("wr4_mem%0d", i), mem[32'h400 + i], 64'h11 * (i + 1));
    chk("wr4_done", done_n, d + 1);
    chk("wr4_wcnt0", cli_wcount, 0);
    chk("wr4_req1", preq_n, p + 1);

    // mismatched write length is rejected without PHY activity
    push(64'hA1); push(64'hA2);
    p = preq_n;
    req(1'b1, 32'h3000, 4'd3);
    chk("mis_ack", cli_ack, 1);
    chk("mis_err", cli_err, 1);
    tick(4);
    chk("mis_nopreq", preq_n, p);
    chk("mis_wcnt", cli_wcount, 2);
    chk("mis_busy", busy, 0);

    // two-beat write with a simultaneous (ignored) push
    cli_wpush = 1'b1; cli_wdata = 64'hBAD;
    req(1'b1, 32'h3000, 4'd1);
    cli_wpush = 1'b0;
    chk("wr2_wcnt", cli_wcount, 2);
    wait_end("wr2_end", 50);
    chk("wr2_mem0", mem[32'h600], 64'hA1);
    chk("wr2_mem1", mem[32'h601], 64'hA2);
    chk("wr2_mem2", mem[32'h602], 64'h0);

    // full buffer: the 17th push is dropped
    for (int i = 0; i < 17; i++) push(64'h5000 + i);
    chk("full_wcnt", cli_wcount, 16);
    req(1'b1, 32'h4000, 4'd15);
    wait_end("wr16_end", 80);
    chk("wr16_mem0", mem[32'h800], 64'h5000);
    chk("wr16_mem15", mem[32'h80F], 64'h500F);
    chk("wr16_wcnt", cli_wcount, 0);

    // read timeout: PHY never returns data
    rd_mute = 1; rd_n = 0; e = err_n;
    req(1'b0, 32'h500, 4'd0);
    wait_end("to_end", 200);
    chk("to_err", err_n, e + 1);
    chk("to_cyc", err_cyc - acc_cyc, TMO);
    chk("to_busy", busy, 0);
    tick();
    chk("to_busy2", busy, 0);
    chk("to_nobeat", rd_n, 0);
    rd_mute = 0;

    // max unaligned burst read
    for (int i = 0; i < 16; i++) mem[32'h200 + i] = 64'hA5A5_0000_0000_0000 + 3 * i + 1;
    rd_n = 0;
    req(1'b0, 32'h1007, 4'd15);
    chk("rd16_addr", phy_addr, 32'h1000);
    chk("rd16_blen", phy_burst_len, 15);
    wait_end("rd16_end", 80);
    chk("rd16_n", rd_n, 16);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("rd16_beat%0d", i), rd_beat[i], i);
      chk($sformatf("rd16_data%0d", i), rd_data[i], 64'hA5A5_0000_0000_0000 + 3 * i + 1);
      chk($sformatf("rd16_last%0d", i), rd_last[i], (i == 15));
    end

    // reset in the middle of a write, at beat 2
    push(64'hC1); push(64'hC2); push(64'hC3); push(64'hC4);
    d = done_n;
    req(1'b1, 32'h2800, 4'd3);
    k = 0;
    while (phy_wdata !== 64'hC3 && k < 20) begin tick(); k++; end
    chk("rst_reach", 64'(k < 20), 1);
    sys_rst = 1'b1;
    tick();
    chk("mrst_preq", phy_req, 0);
    chk("mrst_addr", phy_addr, 0);
    chk("mrst_wen", phy_wen, 0);
    chk("mrst_wdata", phy_wdata, 0);
    chk("mrst_blen", phy_burst_len, 0);
    chk("mrst_wcnt", cli_wcount, 0);
    chk("mrst_rdata", cli_rdata, 0);
    chk("mrst_flags", {cli_ack, cli_rvalid, cli_done, cli_err, busy, cli_rbeat}, 0);
    sys_rst = 1'b0;
    tick(10);
    chk("mrst_nodone", done_n, d);
    chk("mrst_idle", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
endmodule
